// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-controller states, frame geometry and parity selectors.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2
    } rx_ctrl_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_FRAME_W    = 9;
    localparam bit PARITY_EVEN     = 1'b0;
    localparam bit PARITY_ODD      = 1'b1;

    function automatic logic frame_parity(input logic [UART_FRAME_W-1:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; shared by the rx and tx paths.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// Sequences the oversampling UART receiver: baud divider, ready synchroniser, frame capture,
// parity check, sticky error flags and the byte FIFO toward the consumer.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    output logic                          baud_tick,
    output logic                          rx_rst_n,
    input  logic [UART_FRAME_W-1:0]       rx_frame,
    input  logic                          rx_frame_ready,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);
    // state | meaning
    // IDLE  | receiver held in reset, divider parked at 0
    // ARMED | receiver running, waiting for a completed frame
    // CHECK | one cycle: parity check and push/drop of frame_q
    localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    rx_ctrl_state_t          state;
    rx_ctrl_state_t          state_nxt;
    logic [DIV_W-1:0]        div_q;
    logic [2:0]              sync_q;
    logic [UART_FRAME_W-1:0] frame_q;
    logic                    rx_rst_q;
    logic                    parity_err_q;
    logic                    overrun_q;
    logic                    rise;
    logic                    in_check;
    logic                    par_ok;
    logic                    pop;
    logic                    push;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign rise     = sync_q[1] & ~sync_q[2];
    assign in_check = (state == CHECK) & en;
    assign par_ok   = (frame_parity(frame_q) == PARITY_ODD);
    assign pop      = m_valid & m_ready;
    assign push     = in_check & par_ok & (~fifo_full | pop);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)   state_nxt = ARMED;
            ARMED:   if (rise) state_nxt = CHECK;
            CHECK:   state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            div_q        <= '0;
            sync_q       <= '0;
            frame_q      <= '0;
            rx_rst_q     <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_q   <= {sync_q[1:0], rx_frame_ready};
            rx_rst_q <= (state_nxt != IDLE);
            if (state == IDLE || div_q == DIV_LAST) div_q <= '0;
            else                                    div_q <= div_q + 1'b1;
            if (state == ARMED && rise && en) frame_q <= rx_frame;
            // a new error in the clearing cycle must not be lost
            parity_err_q <= (in_check & ~par_ok) | (parity_err_q & ~err_clr);
            overrun_q    <= (in_check & par_ok & fifo_full & ~pop) | (overrun_q & ~err_clr);
        end
    end

    assign rx_rst_n   = rx_rst_q;
    assign baud_tick  = rx_rst_q & en & (div_q == DIV_LAST);
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign m_valid    = ~fifo_empty;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (frame_q[7:0]),
        .pop       (pop),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
